multi_edge_detector: RTL and testbench

//  NUM_CH-channel edge detector for asynchronous inputs (buttons, external strobes, IRQ lines).
//  Per channel: synchroniser, debounce filter, rising/falling pulses, mode-qualified event pulse,

---
 rtl/edge_pkg.sv | 11 +
 rtl/edge_channel.sv | 106 ++++++++++
 rtl/multi_edge_detector.sv | 48 ++++
 tb/tb_multi_edge_detector.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared types for the multi-channel edge detector.
package edge_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

endpackage

// File: rtl/edge_channel.sv
// One channel: synchroniser, debounce filter, edge pulses, mode-qualified event,
// sticky flag and saturating event counter.
module edge_channel
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_i,
  input  logic             enable_i,
  input  edge_mode_t       mode_i,
  input  logic             clear_i,
  output logic             level_o,
  output logic             rising_edge_o,
  output logic             falling_edge_o,
  output logic             event_o,
  output logic             sticky_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int               DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DB_W-1:0]        r_db_cnt;
  logic                   r_level;
  logic                   r_level_d;
  logic                   r_sticky;
  logic [CNT_W-1:0]       r_count;

  logic w_sync;
  logic w_rising;
  logic w_falling;
  logic w_rise_sel;
  logic w_fall_sel;
  logic w_event;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], a_i};
    end
  end

  // The filtered level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_db_cnt  <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
    end else begin
      r_level_d <= r_level;
      if (w_sync != r_level) begin
        if (r_db_cnt == DB_LAST) begin
          r_level  <= w_sync;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  assign w_rising   = r_level & ~r_level_d;
  assign w_falling  = ~r_level & r_level_d;
  assign w_rise_sel = (mode_i == EDGE_RISE) || (mode_i == EDGE_BOTH);
  assign w_fall_sel = (mode_i == EDGE_FALL) || (mode_i == EDGE_BOTH);
  assign w_event    = enable_i & ((w_rise_sel & w_rising) | (w_fall_sel & w_falling));

  // A coincident event wins over clear, so the new event is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sticky <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_event) begin
        r_sticky <= 1'b1;
      end else if (clear_i) begin
        r_sticky <= 1'b0;
      end
      if (clear_i) begin
        r_count <= w_event ? CNT_W'(1) : '0;
      end else if (w_event && (r_count != CNT_MAX)) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign level_o        = r_level;
  assign rising_edge_o  = w_rising;
  assign falling_edge_o = w_falling;
  assign event_o        = w_event;
  assign sticky_o       = r_sticky;
  assign count_o        = r_count;

endmodule

// File: rtl/multi_edge_detector.sv
// NUM_CH independent filtered edge detectors plus a global any-event flag.
module multi_edge_detector
  import edge_pkg::*;
#(
  parameter int NUM_CH          = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       a_i,
  input  logic [NUM_CH-1:0]       enable_i,
  input  logic [2*NUM_CH-1:0]     mode_i,
  input  logic [NUM_CH-1:0]       clear_i,
  output logic [NUM_CH-1:0]       level_o,
  output logic [NUM_CH-1:0]       rising_edge_o,
  output logic [NUM_CH-1:0]       falling_edge_o,
  output logic [NUM_CH-1:0]       event_o,
  output logic [NUM_CH-1:0]       sticky_o,
  output logic                    any_event_o,
  output logic [NUM_CH*CNT_W-1:0] count_o
);

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    edge_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk           (clk),
      .reset         (reset),
      .a_i           (a_i[n]),
      .enable_i      (enable_i[n]),
      .mode_i        (edge_mode_t'(mode_i[2*n +: 2])),
      .clear_i       (clear_i[n]),
      .level_o       (level_o[n]),
      .rising_edge_o (rising_edge_o[n]),
      .falling_edge_o(falling_edge_o[n]),
      .event_o       (event_o[n]),
      .sticky_o      (sticky_o[n]),
      .count_o       (count_o[n*CNT_W +: CNT_W])
    );
  end

  assign any_event_o = |sticky_o;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench: default 8-channel instance plus a 1-channel CNT_W=2 instance for saturation.
module tb_multi_edge_detector;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  a_i, enable_i, clear_i;
  logic [15:0] mode_i;
  logic [7:0]  level_o, rising_edge_o, falling_edge_o, event_o, sticky_o;
  logic        any_event_o;
  logic [63:0] count_o;

  logic       s_a, s_en, s_clr;
  logic [1:0] s_mode;
  logic       s_level, s_rise, s_fall, s_event, s_sticky, s_any;
  logic [1:0] s_count;

  int n_cmp = 0;
  int n_bad = 0;

  multi_edge_detector dut (
    .clk(clk), .reset(reset), .a_i(a_i), .enable_i(enable_i), .mode_i(mode_i),
    .clear_i(clear_i), .level_o(level_o), .rising_edge_o(rising_edge_o),
    .falling_edge_o(falling_edge_o), .event_o(event_o), .sticky_o(sticky_o),
    .any_event_o(any_event_o), .count_o(count_o)
  );

  multi_edge_detector #(.NUM_CH(1), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .a_i(s_a), .enable_i(s_en), .mode_i(s_mode),
    .clear_i(s_clr), .level_o(s_level), .rising_edge_o(s_rise),
    .falling_edge_o(s_fall), .event_o(s_event), .sticky_o(s_sticky),
    .any_event_o(s_any), .count_o(s_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    a_i      = '0; enable_i = '0; clear_i = '0; mode_i = '0;
    s_a      = 1'b0; s_en = 1'b0; s_clr = 1'b0; s_mode = 2'b00;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_i = '0; enable_i = '0; clear_i = '0; mode_i = '0;
    s_a = 1'b0; s_en = 1'b0; s_clr = 1'b0; s_mode = 2'b00;
    repeat (2) tick();
    n_cmp++;
    if ({level_o, rising_edge_o, falling_edge_o, event_o, sticky_o, any_event_o, count_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_idle: got outputs %h expected all zero",
               {level_o, rising_edge_o, falling_edge_o, event_o, sticky_o, any_event_o, count_o});
    end
    // ch0..7 modes NONE,RISE,FALL,BOTH,RISE,BOTH,RISE,BOTH; ch7 disabled
    reset    = 1'b0;
    mode_i   = 16'hDDE4;
    enable_i = 8'h7F;
    a_i      = 8'hFF;
    repeat (12) tick();
    n_cmp++;
    if (count_o !== 64'h0001010101000100) begin
      n_bad++; $display("FAIL reset_prerun_count: got %h expected %h", count_o, 64'h0001010101000100);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({level_o, rising_edge_o, falling_edge_o, event_o, sticky_o, any_event_o, count_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_async_clear: got outputs %h expected all zero",
               {level_o, rising_edge_o, falling_edge_o, event_o, sticky_o, any_event_o, count_o});
    end
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k < 6) begin
        n_cmp++;
        if (level_o !== 8'h00 || rising_edge_o !== 8'h00) begin
          n_bad++; $display("FAIL reset_latency_k%0d: got level %h rise %h expected 00 00", k, level_o, rising_edge_o);
        end
      end else if (k == 6) begin
        n_cmp++;
        if (level_o !== 8'hFF || rising_edge_o !== 8'hFF || event_o !== 8'h7A) begin
          n_bad++;
          $display("FAIL reset_rise_p6: got level %h rise %h event %h expected ff ff 7a",
                   level_o, rising_edge_o, event_o);
        end
      end else if (k == 7) begin
        n_cmp++;
        if (rising_edge_o !== 8'h00 || count_o !== 64'h0001010101000100 ||
            sticky_o !== 8'h7A || any_event_o !== 1'b1) begin
          n_bad++;
          $display("FAIL reset_after_p7: got rise %h count %h sticky %h any %b expected 00 0001010101000100 7a 1",
                   rising_edge_o, count_o, sticky_o, any_event_o);
        end
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    mode_i = 16'h0003; enable_i = 8'h01;
    a_i[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 3) a_i[0] = 1'b0;
      n_cmp++;
      if (level_o[0] !== 1'b0 || rising_edge_o[0] !== 1'b0) begin
        n_bad++; $display("FAIL glitch3_k%0d: got level %b rise %b expected 0 0", k, level_o[0], rising_edge_o[0]);
      end
    end
    a_i[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 4) a_i[0] = 1'b0;
      n_cmp++;
      if (level_o[0] !== (k >= 6 && k < 10) || rising_edge_o[0] !== (k == 6) ||
          falling_edge_o[0] !== (k == 10)) begin
        n_bad++;
        $display("FAIL glitch4_k%0d: got level %b rise %b fall %b expected %b %b %b", k,
                 level_o[0], rising_edge_o[0], falling_edge_o[0], (k >= 6 && k < 10), (k == 6), (k == 10));
      end
    end
  endtask

  task automatic test_modes();
    logic [3:0] rise_seen, fall_seen;
    do_reset();
    mode_i = 16'h00E4; enable_i = 8'hFF;
    rise_seen = '0; fall_seen = '0;
    a_i[3:0] = 4'hF;
    for (int k = 1; k <= 22; k++) begin
      tick();
      if (k == 10) a_i[3:0] = 4'h0;
      rise_seen |= rising_edge_o[3:0];
      fall_seen |= falling_edge_o[3:0];
      if (k == 6) begin
        n_cmp++;
        if (event_o[3:0] !== 4'b1010) begin
          n_bad++; $display("FAIL modes_rise_event: got %b expected 1010", event_o[3:0]);
        end
      end
      if (k == 16) begin
        n_cmp++;
        if (event_o[3:0] !== 4'b1100 || falling_edge_o[3:0] !== 4'hF) begin
          n_bad++; $display("FAIL modes_fall_event: got event %b fall %b expected 1100 1111", event_o[3:0], falling_edge_o[3:0]);
        end
      end
    end
    n_cmp++;
    if (count_o[31:0] !== 32'h02010100) begin
      n_bad++; $display("FAIL modes_counts: got %h expected 02010100", count_o[31:0]);
    end
    n_cmp++;
    if (rise_seen !== 4'hF || fall_seen !== 4'hF) begin
      n_bad++; $display("FAIL modes_edges_seen: got rise %b fall %b expected 1111 1111", rise_seen, fall_seen);
    end
  endtask

  task automatic test_enable_gating();
    int rises, falls;
    logic ev_seen;
    do_reset();
    mode_i = 16'h0003; enable_i = 8'hFE;
    rises = 0; falls = 0; ev_seen = 1'b0;
    for (int p = 0; p < 3; p++) begin
      for (int k = 1; k <= 16; k++) begin
        a_i[0] = (k <= 8);
        tick();
        rises += int'(rising_edge_o[0]);
        falls += int'(falling_edge_o[0]);
        ev_seen |= event_o[0];
      end
    end
    n_cmp++;
    if (rises != 3 || falls != 3) begin
      n_bad++; $display("FAIL enable_edges: got rises %0d falls %0d expected 3 3", rises, falls);
    end
    n_cmp++;
    if (ev_seen !== 1'b0 || sticky_o[0] !== 1'b0 || count_o[7:0] !== 8'h00) begin
      n_bad++;
      $display("FAIL enable_gated: got event %b sticky %b count %h expected 0 0 00", ev_seen, sticky_o[0], count_o[7:0]);
    end
  endtask

  task automatic test_clear();
    do_reset();
    mode_i = 16'h000C; enable_i = 8'h02;
    for (int s = 0; s < 5; s++) begin
      a_i[1] = ~s[0];
      repeat (8) tick();
    end
    n_cmp++;
    if (sticky_o[1] !== 1'b1 || count_o[15:8] !== 8'd5) begin
      n_bad++; $display("FAIL clear_setup: got sticky %b count %0d expected 1 5", sticky_o[1], count_o[15:8]);
    end
    clear_i[1] = 1'b1;
    tick();
    clear_i[1] = 1'b0;
    n_cmp++;
    if (sticky_o[1] !== 1'b0 || count_o[15:8] !== 8'd0) begin
      n_bad++; $display("FAIL clear_alone: got sticky %b count %0d expected 0 0", sticky_o[1], count_o[15:8]);
    end
    a_i[1] = 1'b0;
    repeat (8) tick();
    a_i[1] = 1'b1;
    repeat (6) tick();
    n_cmp++;
    if (event_o[1] !== 1'b1 || count_o[15:8] !== 8'd1) begin
      n_bad++; $display("FAIL clear_pre_event: got event %b count %0d expected 1 1", event_o[1], count_o[15:8]);
    end
    clear_i[1] = 1'b1;
    tick();
    clear_i[1] = 1'b0;
    n_cmp++;
    if (sticky_o[1] !== 1'b1 || count_o[15:8] !== 8'd1) begin
      n_bad++; $display("FAIL clear_with_event: got sticky %b count %0d expected 1 1", sticky_o[1], count_o[15:8]);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt;
    do_reset();
    s_mode = 2'b11; s_en = 1'b1;
    for (int seg = 1; seg <= 6; seg++) begin
      s_a = seg[0];
      for (int t = 1; t <= 8; t++) begin
        tick();
        if (seg > 1 || t >= 7) begin
          n_cmp++;
          if (s_any !== 1'b1) begin
            n_bad++; $display("FAIL sat_any_seg%0d_t%0d: got %b expected 1", seg, t, s_any);
          end
        end
      end
      exp_cnt = (seg >= 3) ? 2'd3 : 2'(seg);
      n_cmp++;
      if (s_count !== exp_cnt) begin
        n_bad++; $display("FAIL sat_count_edge%0d: got %0d expected %0d", seg, s_count, exp_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_modes();
    test_enable_gating();
    test_clear();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
